core_mem_arbiter: RTL
=====================

# core_mem_arbiter

Two-port arbiter that shares the single core-side memory bus between the L1 instruction cache miss port and the L1 data cache miss/writeback port. Each side gets a qword-wide request/ready handshake. The arbiter grants one requester at a time with round-robin priority and latches the granted request's address, data and byte enables. It holds the downstream request until memory signals completion, then routes the completion back to the owner. It sits between the two L1 controllers and the memory interconnect, and also exports per-port transaction counters for performance monitoring.

## Interface
Parameters:
- CNT_W, default 32: width of each performance counter. Counters wrap silently.

Ports:
- clk, in, 1: core clock. Single clock domain.
- rst_n, in, 1: asynchronous, active-low reset.
- insn_start, in, 1: instruction-side request. Level; held until insn_ready.
- insn_addr, in, qptr: instruction-side qword address.
- insn_ready, out, 1: one-cycle completion pulse to the instruction side.
- insn_data_rd, out, qword: read data to the instruction side. Valid when insn_ready=1.
- data_start, in, 1: data-side request. Level; held until data_ready.
- data_write, in, 1: 1 means write, 0 means read.
- data_addr, in, qptr: data-side qword address.
- data_data_wr, in, qword: data-side write data.
- data_byte_en, in, 8: data-side byte enables (write only).
- data_ready, out, 1: one-cycle completion pulse to the data side.
- data_data_rd, out, qword: read data to the data side. Valid when data_ready=1.
- mem_start, out, 1: downstream request. Level; held until mem_ready.
- mem_write, out, 1: downstream write flag.
- mem_addr, out, qptr: downstream address.
- mem_data_wr, out, qword: downstream write data.
- mem_byte_en, out, 8: downstream byte enables. All ones for instruction reads.
- mem_ready, in, 1: downstream completion pulse.
- mem_data_rd, in, qword: downstream read data.
- cnt_insn, out, CNT_W: count of completed instruction transactions.
- cnt_data_r, out, CNT_W: count of completed data reads.
- cnt_data_w, out, CNT_W: count of completed data writes.

## Operation
- FSM states: IDLE, INSN, DATA.
- In IDLE:
  - Sample insn_start and data_start.
  - If one is high, go to that port's state.
  - If both are high, grant the port that was not granted last. Track this with a 1-bit `last` register.
  - `last` resets to DATA, so the instruction side wins the first tie.
- On entry to INSN or DATA, register the owner's request into the mem_* output registers:
  - mem_addr, mem_write, mem_data_wr and mem_byte_en.
  - For INSN: mem_write=0 and mem_byte_en=8'hFF.
- The mem_* outputs stay stable for the whole transaction. Requester input changes during a grant are ignored.
- In INSN or DATA, mem_start=1.
- When mem_ready=1:
  - Return to IDLE and update `last` to the current owner.
  - Increment the matching counter. A data-side transaction goes to cnt_data_w if mem_write=1, otherwise cnt_data_r.
- insn_ready = mem_ready AND state==INSN. data_ready = mem_ready AND state==DATA. Both are combinational.
- insn_data_rd and data_data_rd are both wired straight from mem_data_rd. Consumers qualify them with their own ready.
- A mem_ready that arrives in IDLE is ignored: no ready pulse, no counter change.
- Requester rule: start must be low in the cycle after its ready, unless it is issuing a new request. A start still high in IDLE is treated as a new request.

## Timing
- Reset values, applied asynchronously: state=IDLE, last=DATA, mem_start=0, mem_write=0, mem_addr=0, mem_data_wr=0, mem_byte_en=0, all counters=0, insn_ready=0, data_ready=0.
- Request latency: a request sampled in IDLE at cycle n gives mem_start=1 with valid mem_addr at cycle n+1.
- Completion: mem_ready at cycle m gives the owner's ready in the same cycle m. The state is IDLE at m+1, with the counter already incremented at m+1.
- Back-to-back throughput: the next grant is decided at m+1, and its mem_start appears at m+2.
- Minimum turnaround: 1 idle cycle between downstream transactions.
- mem_ready in the first granted cycle (n+1) is legal. It completes the transaction that cycle.
- Reset mid-transaction: mem_start drops immediately and the outstanding transaction is abandoned. Downstream memory must be reset alongside the arbiter.
- Counter overflow: wraps from all-ones to 0.

## Test plan
- Single instruction read:
  - Stimulus: insn_start=1, insn_addr=0x100 at cycle 0; mem_ready=1 at cycle 4 with mem_data_rd=64'hDEADBEEF_CAFEF00D.
  - Required: mem_start=1 and mem_addr=0x100 with mem_byte_en=FF in cycles 1-4; insn_ready=1 only in cycle 4 with that data; data_ready=0 throughout; cnt_insn=1 at cycle 5.
- Data write:
  - Stimulus: data_write=1, data_addr=0x20, data_byte_en=0x0F, data_data_wr=64'h1234; mem_ready after 3 cycles.
  - Required: mem_write=1, mem_byte_en=0x0F; cnt_data_w=1, cnt_data_r=0.
- Simultaneous requests after reset:
  - Stimulus: both start signals held high; each completion immediate.
  - Required: grant order INSN, DATA, INSN, DATA; each mem_start interval separated by one idle cycle.
- Input change mid-grant:
  - Stimulus: while INSN is granted, change insn_addr to 0x999.
  - Required: mem_addr holds the originally latched value.
- Async reset while DATA is granted:
  - Stimulus: assert rst_n=0 mid-transaction.
  - Required: mem_start=0 and counters=0 before the next clock edge; after release, a pending insn_start is granted first.
- Stray mem_ready in IDLE:
  - Stimulus: mem_ready=1 while in IDLE.
  - Required: no ready pulse, all counters unchanged.

Source files
------------

// File: rtl/core_mem_arbiter_if.sv
// rtl/core_mem_arbiter_if.sv - bundle of L1-side and memory-side handshake signals for core_mem_arbiter
interface core_mem_arbiter_if #(
  parameter int AW = 29,
  parameter int DW = 64
) ();
  // instruction-side miss port
  logic          insn_start;
  logic [AW-1:0] insn_addr;
  logic          insn_ready;
  logic [DW-1:0] insn_data_rd;

  // data-side miss/writeback port
  logic          data_start;
  logic          data_write;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_data_wr;
  logic [7:0]    data_byte_en;
  logic          data_ready;
  logic [DW-1:0] data_data_rd;

  // shared downstream memory bus
  logic          mem_start;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_wr;
  logic [7:0]    mem_byte_en;
  logic          mem_ready;
  logic [DW-1:0] mem_data_rd;

  // arbiter view
  modport master (
    input  insn_start, insn_addr,
    input  data_start, data_write, data_addr, data_data_wr, data_byte_en,
    input  mem_ready, mem_data_rd,
    output insn_ready, insn_data_rd,
    output data_ready, data_data_rd,
    output mem_start, mem_write, mem_addr, mem_data_wr, mem_byte_en
  );

  // requester / memory model view
  modport slave (
    output insn_start, insn_addr,
    output data_start, data_write, data_addr, data_data_wr, data_byte_en,
    output mem_ready, mem_data_rd,
    input  insn_ready, insn_data_rd,
    input  data_ready, data_data_rd,
    input  mem_start, mem_write, mem_addr, mem_data_wr, mem_byte_en
  );
endinterface

// File: rtl/core_mem_arbiter.sv
// rtl/core_mem_arbiter.sv - round-robin arbiter sharing the core memory bus between L1 I and D miss ports
module core_mem_arbiter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  core_mem_arbiter_if.master bus,
  output logic [CNT_W-1:0] cnt_insn,
  output logic [CNT_W-1:0] cnt_data_r,
  output logic [CNT_W-1:0] cnt_data_w
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INSN = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;
  // 1 = data side owned the bus last, 0 = instruction side
  logic   r_last_data;
  logic   w_grant_insn;
  logic   w_grant_data;
  logic   w_done;

  // Next-state decision: ties in IDLE go to the side not served last
  always_comb begin
    w_next_state = r_state;
    w_grant_insn = 1'b0;
    w_grant_data = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.insn_start && bus.data_start) begin
          if (r_last_data) begin
            w_grant_insn = 1'b1;
          end else begin
            w_grant_data = 1'b1;
          end
        end else if (bus.insn_start) begin
          w_grant_insn = 1'b1;
        end else if (bus.data_start) begin
          w_grant_data = 1'b1;
        end
        if (w_grant_insn) begin
          w_next_state = ST_INSN;
        end else if (w_grant_data) begin
          w_next_state = ST_DATA;
        end
      end
      ST_INSN, ST_DATA: begin
        if (bus.mem_ready) begin
          w_done       = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State and round-robin history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_last_data <= 1'b1;
    end else begin
      r_state <= w_next_state;
      if (w_done) begin
        r_last_data <= (r_state == ST_DATA);
      end
    end
  end

  // Latch the winner's request on grant; held untouched until completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_write   <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_data_wr <= '0;
      bus.mem_byte_en <= 8'h00;
    end else if (w_grant_insn) begin
      bus.mem_write   <= 1'b0;
      bus.mem_addr    <= bus.insn_addr;
      bus.mem_data_wr <= bus.data_data_wr;
      bus.mem_byte_en <= 8'hFF;
    end else if (w_grant_data) begin
      bus.mem_write   <= bus.data_write;
      bus.mem_addr    <= bus.data_addr;
      bus.mem_data_wr <= bus.data_data_wr;
      bus.mem_byte_en <= bus.data_byte_en;
    end
  end

  // Per-port completion counters, wrapping silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_insn   <= '0;
      cnt_data_r <= '0;
      cnt_data_w <= '0;
    end else if (w_done) begin
      if (r_state == ST_INSN) begin
        cnt_insn <= cnt_insn + CNT_W'(1);
      end else if (bus.mem_write) begin
        cnt_data_w <= cnt_data_w + CNT_W'(1);
      end else begin
        cnt_data_r <= cnt_data_r + CNT_W'(1);
      end
    end
  end

  // Request is asserted for as long as a port owns the bus; a reset drops it at once
  assign bus.mem_start    = (r_state != ST_IDLE);

  // Completion is routed to the owner only; stray mem_ready in IDLE falls through
  assign bus.insn_ready   = bus.mem_ready && (r_state == ST_INSN);
  assign bus.data_ready   = bus.mem_ready && (r_state == ST_DATA);
  assign bus.insn_data_rd = bus.mem_data_rd;
  assign bus.data_data_rd = bus.mem_data_rd;

endmodule
